// File: rtl/pipe_pkg.sv
// Shared types for the RV32I inter-stage pipeline registers: occupancy states
// and the packed control bundles callers use to build in_ctrl.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  localparam int CTRL_BITS = 8;
  localparam logic [CTRL_BITS-1:0] NOP_CTRL = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
  } exe_ctrl_t;

  // All-zero fields pack to NOP_CTRL, so an idle stage decodes as a bubble.
  function automatic logic [CTRL_BITS-1:0] pack_ctrl(wb_ctrl_t wb, mem_ctrl_t mem, exe_ctrl_t exe);
    return {wb, mem, exe};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag plus control and data bundles.
// clear has priority over load; a cleared slot always presents a NOP control.
module pipe_slot #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 128,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      if (CLR_DATA) data_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      ctrl_reg  <= d_ctrl;
      data_reg  <= d_data;
    end
  end

  assign valid = valid_reg;
  assign ctrl  = ctrl_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register between RV32I stages, with flush, optional
// two-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int CTRL_W   = 8,
  parameter bit SKID     = 1'b1,
  parameter int CNT_W    = 16,
  parameter bit CLR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              cnt_clr
);

  logic              in_xfer;
  logic              out_xfer;
  logic              main_load;
  logic              main_clear;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  logic [CNT_W-1:0]  stall_cnt_reg;

  // A transfer presented together with flush is dropped.
  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (out_valid),
    .ctrl   (out_ctrl),
    .data   (out_data)
  );

  generate
    if (SKID) begin : g_skid
      stage_state_e      state_reg;
      logic              in_ready_reg;
      logic              skid_load;
      logic              skid_clear;
      logic              skid_valid;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // Main refills from the skid slot only when leaving FULL, which keeps order.
      assign main_load   = (state_reg == EMPTY && in_xfer)
                        || (state_reg == BUSY && in_xfer && out_ready)
                        || (state_reg == FULL && out_xfer && !flush);
      assign main_clear  = flush || (state_reg == BUSY && out_xfer && !in_xfer);
      assign main_d_ctrl = (state_reg == FULL) ? skid_ctrl : in_ctrl;
      assign main_d_data = (state_reg == FULL) ? skid_data : in_data;
      assign skid_load   = state_reg == BUSY && in_xfer && !out_ready;
      assign skid_clear  = flush || (state_reg == FULL && out_xfer);
      assign in_ready    = in_ready_reg;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (in_ctrl),
        .d_data (in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .data   (skid_data)
      );

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg    <= EMPTY;
          in_ready_reg <= 1'b1;
        end else if (flush) begin
          state_reg    <= EMPTY;
          in_ready_reg <= 1'b1;
        end else begin
          case (state_reg)
            EMPTY: if (in_xfer) state_reg <= BUSY;
            BUSY: begin
              if (in_xfer && !out_ready) begin
                state_reg    <= FULL;
                in_ready_reg <= 1'b0;
              end else if (out_xfer && !in_xfer) begin
                state_reg <= EMPTY;
              end
            end
            FULL: begin
              if (out_xfer) begin
                state_reg    <= BUSY;
                in_ready_reg <= 1'b1;
              end
            end
            default: begin
              state_reg    <= EMPTY;
              in_ready_reg <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_single
      assign in_ready    = !out_valid || out_ready;
      assign main_load   = in_xfer;
      assign main_clear  = flush || (out_xfer && !in_xfer);
      assign main_d_ctrl = in_ctrl;
      assign main_d_data = in_data;
    end
  endgenerate

  // Saturating profiler; clear beats increment, flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (cnt_clr) begin
      stall_cnt_reg <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a skid instance (CNT_W=4, CLR_DATA=1) and a single-register
// instance (CLR_DATA=0), each compared against a queue-based model of the stage.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        v1, r1, fl1, clr1, in_ready1, out_valid1;
  logic [7:0]  c1, out_ctrl1;
  logic [31:0] d1, out_data1;
  logic [3:0]  stall1;

  logic        v0, r0, fl0, clr0, in_ready0, out_valid0;
  logic [7:0]  c0, out_ctrl0;
  logic [31:0] d0, out_data0;
  logic [15:0] stall0;

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(8), .SKID(1), .CNT_W(4), .CLR_DATA(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(v1), .in_ready(in_ready1),
    .in_ctrl(c1), .in_data(d1), .out_valid(out_valid1), .out_ready(r1),
    .out_ctrl(out_ctrl1), .out_data(out_data1), .stall_cnt(stall1), .cnt_clr(clr1)
  );

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(8), .SKID(0), .CNT_W(16), .CLR_DATA(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(v0), .in_ready(in_ready0),
    .in_ctrl(c0), .in_data(d0), .out_valid(out_valid0), .out_ready(r0),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .stall_cnt(stall0), .cnt_clr(clr0)
  );

  int checks = 0;
  int errors = 0;

  // Model: a FIFO of {ctrl,data}, capacity 2 (skid) or 1 (single register).
  logic [39:0] q1[$];
  logic [39:0] q0[$];
  logic        m1_rdy;
  int          m1_cnt, m0_cnt;
  logic [31:0] m0_last;

  function automatic logic [7:0] e1_ctrl();
    return (q1.size() > 0) ? q1[0][39:32] : 8'h00;
  endfunction
  function automatic logic [31:0] e1_data();
    return (q1.size() > 0) ? q1[0][31:0] : 32'h0;
  endfunction
  function automatic logic [7:0] e0_ctrl();
    return (q0.size() > 0) ? q0[0][39:32] : 8'h00;
  endfunction

  task automatic model_reset();
    q1.delete();
    q0.delete();
    m1_rdy  = 1'b1;
    m1_cnt  = 0;
    m0_cnt  = 0;
    m0_last = 32'h0;
  endtask

  // Advance model by one clock using the inputs as driven, then step the DUTs.
  task automatic tick();
    logic x1_in, x1_out, x0_in, x0_out, rdy0;
    x1_out = (q1.size() > 0) && r1;
    x1_in  = v1 && m1_rdy && !fl1;
    rdy0   = (q0.size() == 0) || r0;
    x0_out = (q0.size() > 0) && r0;
    x0_in  = v0 && rdy0 && !fl0;
    if (clr1) m1_cnt = 0;
    else if ((q1.size() > 0) && !r1 && (m1_cnt < 15)) m1_cnt++;
    if (clr0) m0_cnt = 0;
    else if ((q0.size() > 0) && !r0 && (m0_cnt < 65535)) m0_cnt++;
    if (x1_out) $display("dut1 xfer ctrl=%h data=%h", q1[0][39:32], q1[0][31:0]);
    if (x0_out) $display("dut0 xfer ctrl=%h data=%h", q0[0][39:32], q0[0][31:0]);
    if (fl1) q1.delete();
    else begin
      if (x1_out) void'(q1.pop_front());
      if (x1_in) q1.push_back({c1, d1});
    end
    m1_rdy = (q1.size() < 2);
    if (fl0) q0.delete();
    else begin
      if (x0_out) void'(q0.pop_front());
      if (x0_in) begin
        q0.push_back({c0, d0});
        m0_last = d0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid1: got %b expected 0", out_valid1); end
    checks++; if (out_ctrl1 !== 8'h00) begin errors++; $display("FAIL rst_ctrl1: got %h expected 00", out_ctrl1); end
    checks++; if (out_data1 !== 32'h0) begin errors++; $display("FAIL rst_data1: got %h expected 0", out_data1); end
    checks++; if (stall1 !== 4'h0) begin errors++; $display("FAIL rst_stall1: got %h expected 0", stall1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_ready1: got %b expected 1", in_ready1); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL rst_ready0: got %b expected 1", in_ready0); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid0: got %b expected 0", out_valid0); end
    v1 = 1'b1; r1 = 1'b0; c1 = 8'h5A; d1 = 32'h1234;
    tick();
    d1 = 32'h1235;
    tick();
    checks++; if (out_valid1 !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b expected 1", out_valid1); end
    checks++; if (stall1 !== 4'h1) begin errors++; $display("FAIL pre_rst_stall: got %h expected 1", stall1); end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", out_valid1); end
    checks++; if (out_ctrl1 !== 8'h00) begin errors++; $display("FAIL async_rst_ctrl: got %h expected 00", out_ctrl1); end
    checks++; if (stall1 !== 4'h0) begin errors++; $display("FAIL async_rst_stall: got %h expected 0", stall1); end
    v1 = 1'b0;
    #2 rst = 1'b1;
    tick();
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", in_ready1); end
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", out_valid1); end
  endtask

  task automatic test_streaming();
    logic [7:0] c;
    r1 = 1'b1; r0 = 1'b1; v1 = 1'b1; v0 = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      c = 8'($urandom_range(1, 255));
      c1 = c; c0 = c; d1 = i; d0 = i;
      #1;
      checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL stream_ready1 #%0d: got %b expected 1", i, in_ready1); end
      checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL stream_ready0 #%0d: got %b expected 1", i, in_ready0); end
      tick();
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'(i)) begin errors++; $display("FAIL stream_data1 #%0d: got v=%b %h expected v=1 %h", i, out_valid1, out_data1, i); end
      checks++; if (out_ctrl1 !== c) begin errors++; $display("FAIL stream_ctrl1 #%0d: got %h expected %h", i, out_ctrl1, c); end
      checks++; if (out_valid0 !== 1'b1 || out_data0 !== 32'(i)) begin errors++; $display("FAIL stream_data0 #%0d: got v=%b %h expected v=1 %h", i, out_valid0, out_data0, i); end
    end
    v1 = 1'b0; v0 = 1'b0;
    tick();
    checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 8'h00) begin errors++; $display("FAIL bubble1: got v=%b ctrl=%h expected v=0 ctrl=00", out_valid1, out_ctrl1); end
    checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== 8'h00) begin errors++; $display("FAIL bubble0: got v=%b ctrl=%h expected v=0 ctrl=00", out_valid0, out_ctrl0); end
  endtask

  task automatic test_backpressure();
    int nxt, exp, guard;
    logic acc;
    r1 = 1'b1; clr1 = 1'b1; v1 = 1'b1; c1 = 8'h11; d1 = 32'd200;
    tick();
    clr1 = 1'b0; r1 = 1'b0; nxt = 201;
    for (int k = 0; k < 5; k++) begin
      v1 = 1'b1; d1 = 32'(nxt);
      acc = m1_rdy;
      tick();
      if (acc) nxt++;
      checks++; if (out_valid1 !== 1'b1 || out_data1 !== 32'd200) begin errors++; $display("FAIL bp_frozen cyc%0d: got v=%b %0d expected v=1 200", k, out_valid1, out_data1); end
    end
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", in_ready1); end
    checks++; if (stall1 !== 4'd5) begin errors++; $display("FAIL bp_stall: got %0d expected 5", stall1); end
    checks++; if (nxt != 202) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", nxt - 200); end
    r1 = 1'b1; exp = 200; guard = 0;
    while (exp <= 210 && guard < 40) begin
      v1 = (nxt <= 210); d1 = 32'(nxt);
      acc = v1 && m1_rdy;
      #1;
      if (out_valid1) begin
        checks++; if (out_data1 !== 32'(exp)) begin errors++; $display("FAIL bp_order: got %0d expected %0d", out_data1, exp); end
        exp++;
      end
      tick();
      if (acc) nxt++;
      guard++;
    end
    v1 = 1'b0;
    checks++; if (exp != 211) begin errors++; $display("FAIL bp_drained: got %0d items expected 11", exp - 200); end
    tick();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got valid=%b expected 0", out_valid1); end
  endtask

  task automatic test_flush();
    r1 = 1'b0; v1 = 1'b1; c1 = 8'h22; d1 = 32'd300;
    tick();
    d1 = 32'd301;
    tick();
    checks++; if (in_ready1 !== 1'b0) begin errors++; $display("FAIL fl_full: got ready=%b expected 0", in_ready1); end
    c1 = 8'hAA; d1 = 32'hAA; fl1 = 1'b1;
    tick();
    fl1 = 1'b0; v1 = 1'b0;
    checks++; if (out_valid1 !== 1'b0 || out_ctrl1 !== 8'h00) begin errors++; $display("FAIL fl_out: got v=%b ctrl=%h expected v=0 ctrl=00", out_valid1, out_ctrl1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL fl_ready: got %b expected 1", in_ready1); end
    checks++; if (out_data1 !== 32'h0) begin errors++; $display("FAIL fl_clrdata: got %h expected 0", out_data1); end
    checks++; if (stall1 !== 4'(m1_cnt)) begin errors++; $display("FAIL fl_keep_cnt: got %0d expected %0d", stall1, m1_cnt); end
    r1 = 1'b1; v1 = 1'b1; fl1 = 1'b1;
    tick();
    fl1 = 1'b0; v1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid1 !== 1'b0 || out_data1 !== 32'h0) begin errors++; $display("FAIL fl_discard cyc%0d: got v=%b %h expected v=0 0", k, out_valid1, out_data1); end
      tick();
    end
    r0 = 1'b1; v0 = 1'b1; c0 = 8'h33; d0 = 32'h55;
    tick();
    c0 = 8'hAA; d0 = 32'hAA; fl0 = 1'b1;
    tick();
    fl0 = 1'b0; v0 = 1'b0;
    checks++; if (out_valid0 !== 1'b0 || out_ctrl0 !== 8'h00) begin errors++; $display("FAIL fl0_out: got v=%b ctrl=%h expected v=0 ctrl=00", out_valid0, out_ctrl0); end
    checks++; if (out_data0 !== 32'h55) begin errors++; $display("FAIL fl0_hold: got %h expected 55", out_data0); end
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL fl0_ready: got %b expected 1", in_ready0); end
  endtask

  task automatic test_counter();
    v1 = 1'b1; c1 = 8'h44; d1 = 32'd7; r1 = 1'b1; clr1 = 1'b1;
    tick();
    v1 = 1'b0; r1 = 1'b0; clr1 = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    checks++; if (stall1 !== 4'hF) begin errors++; $display("FAIL cnt_sat: got %0d expected 15", stall1); end
    checks++; if (out_data1 !== 32'd7 || out_ctrl1 !== 8'h44) begin errors++; $display("FAIL cnt_hold: got %h/%h expected 44/7", out_ctrl1, out_data1); end
    clr1 = 1'b1;
    tick();
    checks++; if (stall1 !== 4'h0) begin errors++; $display("FAIL cnt_clr: got %0d expected 0", stall1); end
    clr1 = 1'b0;
    tick();
    checks++; if (stall1 !== 4'h1) begin errors++; $display("FAIL cnt_restart: got %0d expected 1", stall1); end
    r1 = 1'b1;
    tick();
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL cnt_drain: got %b expected 0", out_valid1); end
  endtask

  task automatic test_order();
    int s1, s0, cyc;
    logic a1, a0;
    logic [31:0] p1[$];
    logic [31:0] p0[$];
    s1 = 0; s0 = 0; cyc = 0;
    while ((p1.size() < 60 || p0.size() < 60) && cyc < 1500) begin
      v1 = (s1 < 60) && ($urandom_range(0, 2) != 0); d1 = 32'(s1); c1 = 8'($urandom_range(1, 255));
      r1 = ($urandom_range(0, 2) != 0);
      v0 = (s0 < 60) && ($urandom_range(0, 2) != 0); d0 = 32'(s0); c0 = 8'($urandom_range(1, 255));
      r0 = ($urandom_range(0, 2) != 0);
      a1 = v1 && m1_rdy;
      a0 = v0 && ((q0.size() == 0) || r0);
      #1;
      if (out_valid1 && r1) p1.push_back(out_data1);
      if (out_valid0 && r0) p0.push_back(out_data0);
      tick();
      if (a1) s1++;
      if (a0) s0++;
      cyc++;
    end
    v1 = 1'b0; v0 = 1'b0; r1 = 1'b1; r0 = 1'b1;
    tick();
    checks++; if (p1.size() != 60) begin errors++; $display("FAIL ord_count1: got %0d expected 60", p1.size()); end
    checks++; if (p0.size() != 60) begin errors++; $display("FAIL ord_count0: got %0d expected 60", p0.size()); end
    for (int i = 0; i < 60 && i < p1.size() && i < p0.size(); i++) begin
      checks++; if (p1[i] !== 32'(i) || p0[i] !== 32'(i)) begin errors++; $display("FAIL ord_seq #%0d: got skid=%0d single=%0d expected %0d", i, p1[i], p0[i], i); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      v1 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 2) != 0);
      fl1 = ($urandom_range(0, 29) == 0); clr1 = ($urandom_range(0, 39) == 0);
      c1 = 8'($urandom); d1 = $urandom;
      v0 = ($urandom_range(0, 3) != 0); r0 = ($urandom_range(0, 2) != 0);
      fl0 = ($urandom_range(0, 29) == 0); clr0 = ($urandom_range(0, 39) == 0);
      c0 = 8'($urandom); d0 = $urandom;
      #1;
      checks++; if (in_ready0 !== ((q0.size() == 0) || r0)) begin errors++; $display("FAIL rnd_ready0 cyc%0d: got %b expected %b", k, in_ready0, (q0.size() == 0) || r0); end
      checks++; if (in_ready1 !== m1_rdy) begin errors++; $display("FAIL rnd_ready1 cyc%0d: got %b expected %b", k, in_ready1, m1_rdy); end
      tick();
      checks++; if (out_valid1 !== (q1.size() > 0) || out_ctrl1 !== e1_ctrl() || out_data1 !== e1_data()) begin
        errors++; $display("FAIL rnd_out1 cyc%0d: got v=%b %h/%h expected v=%b %h/%h", k, out_valid1, out_ctrl1, out_data1, q1.size() > 0, e1_ctrl(), e1_data());
      end
      checks++; if (out_valid0 !== (q0.size() > 0) || out_ctrl0 !== e0_ctrl() || out_data0 !== m0_last) begin
        errors++; $display("FAIL rnd_out0 cyc%0d: got v=%b %h/%h expected v=%b %h/%h", k, out_valid0, out_ctrl0, out_data0, q0.size() > 0, e0_ctrl(), m0_last);
      end
      checks++; if (stall1 !== 4'(m1_cnt) || stall0 !== 16'(m0_cnt)) begin
        errors++; $display("FAIL rnd_stall cyc%0d: got %0d/%0d expected %0d/%0d", k, stall1, stall0, m1_cnt, m0_cnt);
      end
    end
    fl1 = 1'b0; clr1 = 1'b0; fl0 = 1'b0; clr0 = 1'b0; v1 = 1'b0; v0 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    v1 = 1'b0; r1 = 1'b0; fl1 = 1'b0; clr1 = 1'b0; c1 = '0; d1 = '0;
    v0 = 1'b0; r0 = 1'b0; fl0 = 1'b0; clr0 = 1'b0; c0 = '0; d0 = '0;
    model_reset();
    #23 rst = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_counter();
    test_order();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
